eval_sched: RTL and testbench
=============================

EVAL_SCHED -- requirements
Module: eval_sched

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- VAR_PER_CLAUSE, 5, literals per clause
- MAX_VARS_BITS, 9, variable index width
- CLAUSE_DATA_BITS, 55, clause word width: mask[54:50], pole[49:45], 5x9-bit vars[44:0]
- CLAUSE_ADDR_BITS, 10, clause memory address width
REQ-002 Ports (name, direction, width, meaning), one per line:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse; begin walking a clause list
- base_addr  in  CLAUSE_ADDR_BITS  first clause address, sampled on accepted start
- clause_cnt  in  CLAUSE_ADDR_BITS+1  number of clauses, sampled on accepted start
- abort  in  1  stop the walk at once
- clause_rd_en  out  1  clause memory read strobe
- clause_rd_addr  out  CLAUSE_ADDR_BITS  clause memory address
- clause_rd_data  in  CLAUSE_DATA_BITS  read data, valid the cycle after clause_rd_en
- ep_clause_info  out  CLAUSE_DATA_BITS  clause word to eval_prep
- ep_en  out  1  eval_prep enable
- ce_valid  in  1  clause evaluator result valid
- ce_status  in  2  00 unresolved, 01 sat, 10 unit, 11 conflict
- ce_unit_var  in  MAX_VARS_BITS  implied variable, valid with status unit
- ce_unit_val  in  1  implied value, valid with status unit
- imp_valid  out  1  implication offered
- imp_ready  in  1  implication consumer ready
- imp_var  out  MAX_VARS_BITS  implied variable
- imp_val  out  1  implied value
- busy  out  1  walk in progress
- done  out  1  one-cycle pulse at end of walk
- conflict  out  1  walk ended on conflict; valid with done
- conflict_addr  out  CLAUSE_ADDR_BITS  address of the conflicting clause
- imp_count  out  CLAUSE_ADDR_BITS+1  implications issued this walk

Function
REQ-003 The FSM SHALL have states IDLE, FETCH, LOAD, EVAL, IMPLY and DONE.
REQ-004 In IDLE, start SHALL latch base_addr and clause_cnt, clear imp_count, and go to FETCH; if clause_cnt=0 it SHALL go directly to DONE.
REQ-005 In FETCH: clause_rd_en=1 and clause_rd_addr=current address for exactly one cycle, then LOAD.
REQ-006 In LOAD: clause_rd_data is registered into ep_clause_info, ep_en=1 for exactly one cycle, then EVAL.
REQ-007 EVAL SHALL hold until ce_valid; ce_valid in any other state SHALL be ignored.
- status 00/01: advance to the next clause.
- status 10: register ce_unit_var/ce_unit_val and go to IMPLY.
- status 11: record the current address in conflict_addr, set conflict, and go to DONE.
REQ-008 In IMPLY, imp_valid=1 with stable imp_var/imp_val until imp_ready; on handshake imp_count increments and the walk advances.
REQ-009 Advance: address +1 modulo 2^CLAUSE_ADDR_BITS (wraps), remaining count -1; at remaining count 0 go to DONE, otherwise to FETCH.
REQ-010 Minimum latency: 3 cycles per clause without implication; the done pulse is asserted the cycle after the last advance.
REQ-011 DONE: done=1 for one cycle, then IDLE. conflict, conflict_addr and imp_count hold until the next accepted start.
REQ-012 busy=1 in every state except IDLE; start while busy SHALL be ignored.
REQ-013 abort in any non-IDLE state SHALL go to DONE next cycle with conflict=0, dropping any pending implication; abort outranks ce_valid and imp_ready in the same cycle.
REQ-014 clause_rd_en, ep_en and imp_valid SHALL never be asserted in the same cycle.

Reset
REQ-015 While reset=0 (asynchronous): state IDLE, all outputs 0 (including ep_clause_info, conflict_addr and imp_count), latched address/count cleared.
REQ-016 Reset deassertion mid-walk SHALL resume in IDLE with no done pulse and no pending implication.

Verification
REQ-017 start, base=4, cnt=3, status sat each clause -> reads at 4,5,6, each 3 cycles apart; done with conflict=0, imp_count=0.
REQ-018 base=1, cnt=2; clause 1 unit var=7 val=1, imp_ready held low 4 cycles -> imp_valid stable 5 cycles, imp_count=1, clause 2 read only after handshake.
REQ-019 base=1022, cnt=4, clause at 1023 conflict -> reads 1022,1023 only; done, conflict=1, conflict_addr=1023.
REQ-020 start with cnt=0 -> no clause_rd_en, done the next cycle.
REQ-021 abort in EVAL in the same cycle as ce_valid unit -> no imp_valid, done next cycle, conflict=0.
REQ-022 reset low during IMPLY -> all outputs 0 immediately; a new start with cnt=1 completes normally.

Source files
------------

// File: rtl/eval_sched.sv
// eval_sched: walks a list of clause words from clause memory, hands each one to
// eval_prep, waits for the evaluator verdict and forwards unit implications.
module eval_sched #(
  parameter int VAR_PER_CLAUSE   = 5,
  parameter int MAX_VARS_BITS    = 9,
  parameter int CLAUSE_DATA_BITS = 55,
  parameter int CLAUSE_ADDR_BITS = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [CLAUSE_ADDR_BITS-1:0] base_addr,
  input  logic [CLAUSE_ADDR_BITS:0]   clause_cnt,
  input  logic                        abort,
  output logic                        clause_rd_en,
  output logic [CLAUSE_ADDR_BITS-1:0] clause_rd_addr,
  input  logic [CLAUSE_DATA_BITS-1:0] clause_rd_data,
  output logic [CLAUSE_DATA_BITS-1:0] ep_clause_info,
  output logic                        ep_en,
  input  logic                        ce_valid,
  input  logic [1:0]                  ce_status,
  input  logic [MAX_VARS_BITS-1:0]    ce_unit_var,
  input  logic                        ce_unit_val,
  output logic                        imp_valid,
  input  logic                        imp_ready,
  output logic [MAX_VARS_BITS-1:0]    imp_var,
  output logic                        imp_val,
  output logic                        busy,
  output logic                        done,
  output logic                        conflict,
  output logic [CLAUSE_ADDR_BITS-1:0] conflict_addr,
  output logic [CLAUSE_ADDR_BITS:0]   imp_count
);

  // state | meaning
  // IDLE  | waiting for start
  // FETCH | clause read strobe on the bus
  // LOAD  | read data arriving, captured into ep_clause_info
  // EVAL  | waiting for the evaluator verdict
  // IMPLY | offering the implication until the consumer takes it
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, EVAL, IMPLY, DONE} state_t;

  // Clause word is mask + pole + one var index per literal.
  if (CLAUSE_DATA_BITS != VAR_PER_CLAUSE * (MAX_VARS_BITS + 2)) begin : g_width_check
    $error("clause word width does not match the literal layout");
  end

  state_t                      state_q, state_d;
  logic [CLAUSE_ADDR_BITS-1:0] addr_q, addr_d;
  logic [CLAUSE_ADDR_BITS:0]   remain_q, remain_d;
  logic [CLAUSE_DATA_BITS-1:0] ep_info_q, ep_info_d;
  logic [MAX_VARS_BITS-1:0]    imp_var_q, imp_var_d;
  logic                        imp_val_q, imp_val_d;
  logic                        conflict_q, conflict_d;
  logic [CLAUSE_ADDR_BITS-1:0] conflict_addr_q, conflict_addr_d;
  logic [CLAUSE_ADDR_BITS:0]   imp_count_q, imp_count_d;
  logic                        rd_en_q, rd_en_d;
  logic                        ep_en_q, ep_en_d;
  logic                        imp_valid_q, imp_valid_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        advance;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remain_d        = remain_q;
    ep_info_d       = ep_info_q;
    imp_var_d       = imp_var_q;
    imp_val_d       = imp_val_q;
    conflict_d      = conflict_q;
    conflict_addr_d = conflict_addr_q;
    imp_count_d     = imp_count_q;
    advance         = 1'b0;

    // abort wins over any verdict or handshake arriving in the same cycle
    if (abort && (state_q inside {FETCH, LOAD, EVAL, IMPLY})) begin
      state_d    = DONE;
      conflict_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_d          = base_addr;
            remain_d        = clause_cnt;
            imp_count_d     = '0;
            conflict_d      = 1'b0;
            conflict_addr_d = '0;
            state_d         = (clause_cnt == '0) ? DONE : FETCH;
          end
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          ep_info_d = clause_rd_data;
          state_d   = EVAL;
        end
        EVAL: begin
          if (ce_valid) begin
            case (ce_status)
              2'b10: begin
                imp_var_d = ce_unit_var;
                imp_val_d = ce_unit_val;
                state_d   = IMPLY;
              end
              2'b11: begin
                conflict_d      = 1'b1;
                conflict_addr_d = addr_q;
                state_d         = DONE;
              end
              default: advance = 1'b1;
            endcase
          end
        end
        IMPLY: begin
          if (imp_ready) begin
            imp_count_d = imp_count_q + 1'b1;
            advance     = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase

      if (advance) begin
        addr_d   = addr_q + 1'b1;
        remain_d = remain_q - 1'b1;
        state_d  = (remain_d == '0) ? DONE : FETCH;
      end
    end

    rd_en_d     = (state_d == FETCH);
    ep_en_d     = (state_q == LOAD) && (state_d == EVAL);
    imp_valid_d = (state_d == IMPLY);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      ep_info_q       <= '0;
      imp_var_q       <= '0;
      imp_val_q       <= 1'b0;
      conflict_q      <= 1'b0;
      conflict_addr_q <= '0;
      imp_count_q     <= '0;
      rd_en_q         <= 1'b0;
      ep_en_q         <= 1'b0;
      imp_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      ep_info_q       <= ep_info_d;
      imp_var_q       <= imp_var_d;
      imp_val_q       <= imp_val_d;
      conflict_q      <= conflict_d;
      conflict_addr_q <= conflict_addr_d;
      imp_count_q     <= imp_count_d;
      rd_en_q         <= rd_en_d;
      ep_en_q         <= ep_en_d;
      imp_valid_q     <= imp_valid_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign clause_rd_en   = rd_en_q;
  assign clause_rd_addr = addr_q;
  assign ep_clause_info = ep_info_q;
  assign ep_en          = ep_en_q;
  assign imp_valid      = imp_valid_q;
  assign imp_var        = imp_var_q;
  assign imp_val        = imp_val_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign conflict       = conflict_q;
  assign conflict_addr  = conflict_addr_q;
  assign imp_count      = imp_count_q;

endmodule

// File: tb/tb_eval_sched.sv
// Randomized bench for eval_sched: a clause-list reference model predicts reads,
// implications, end-of-walk results and timing for each walk.
module tb_eval_sched;
  localparam int AW = 10;
  localparam int DW = 55;
  localparam int VW = 9;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   clause_cnt = '0;
  logic          abort = 1'b0;
  logic          clause_rd_en;
  logic [AW-1:0] clause_rd_addr;
  logic [DW-1:0] clause_rd_data = '0;
  logic [DW-1:0] ep_clause_info;
  logic          ep_en;
  logic          ce_valid = 1'b0;
  logic [1:0]    ce_status = '0;
  logic [VW-1:0] ce_unit_var = '0;
  logic          ce_unit_val = 1'b0;
  logic          imp_valid;
  logic          imp_ready = 1'b0;
  logic [VW-1:0] imp_var;
  logic          imp_val;
  logic          busy;
  logic          done;
  logic          conflict;
  logic [AW-1:0] conflict_addr;
  logic [AW:0]   imp_count;

  eval_sched dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .clause_cnt(clause_cnt), .abort(abort), .clause_rd_en(clause_rd_en),
    .clause_rd_addr(clause_rd_addr), .clause_rd_data(clause_rd_data),
    .ep_clause_info(ep_clause_info), .ep_en(ep_en), .ce_valid(ce_valid),
    .ce_status(ce_status), .ce_unit_var(ce_unit_var), .ce_unit_val(ce_unit_val),
    .imp_valid(imp_valid), .imp_ready(imp_ready), .imp_var(imp_var),
    .imp_val(imp_val), .busy(busy), .done(done), .conflict(conflict),
    .conflict_addr(conflict_addr), .imp_count(imp_count)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] mem [0:1023];
  always @(posedge clock) if (clause_rd_en) clause_rd_data <= mem[clause_rd_addr];

  int n_checks = 0;
  int n_errors = 0;
  int walk_id  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL [walk %0d] %s: got=%0h expected=%0h", walk_id, tag, got, exp);
    end
  endtask

  // walk description
  int            s_base, s_cnt, s_abort_idx;
  bit            s_noise, s_rst_imply;
  logic [1:0]    s_st [16];
  logic [VW-1:0] s_var [16];
  logic          s_val [16];
  int            s_ce_dly [16];
  int            s_rdy_dly [16];

  // model predictions
  int          e_reads[$];
  int          e_rd_cyc[$];
  logic [VW:0] e_imps[$];
  int          e_done_cyc, e_conf_addr, e_imp_cnt;
  bit          e_conf;

  function automatic void clear_scen();
    s_abort_idx = -1;
    s_noise     = 1'b0;
    s_rst_imply = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_st[i]      = 2'b01;
      s_var[i]     = VW'($urandom);
      s_val[i]     = 1'($urandom);
      s_ce_dly[i]  = 0;
      s_rdy_dly[i] = 0;
    end
  endfunction

  // FETCH/LOAD/EVAL take 3 cycles plus evaluator delay; a unit adds one IMPLY
  // cycle plus the consumer stall. The walk starts one cycle after start.
  function automatic void build_model();
    int cyc;
    int a;
    e_reads.delete(); e_rd_cyc.delete(); e_imps.delete();
    e_conf = 1'b0; e_conf_addr = 0; e_imp_cnt = 0;
    cyc = 1;
    for (int i = 0; i < s_cnt; i++) begin
      a = (s_base + i) % 1024;
      e_reads.push_back(a);
      e_rd_cyc.push_back(cyc);
      if (i == s_abort_idx) begin cyc += 3 + s_ce_dly[i]; break; end
      if (s_st[i] == 2'b11) begin
        e_conf = 1'b1; e_conf_addr = a;
        cyc += 3 + s_ce_dly[i];
        break;
      end
      if (s_st[i] == 2'b10) begin
        e_imps.push_back({s_var[i], s_val[i]});
        e_imp_cnt++;
        cyc += 4 + s_ce_dly[i] + s_rdy_dly[i];
      end else begin
        cyc += 3 + s_ce_dly[i];
      end
    end
    e_done_cyc = cyc;
  endfunction

  task automatic run_walk();
    int cyc = 0, rd_idx = 0, ep_idx = 0, imp_idx = 0, cur = 0;
    int ce_wait = -1, rdy_wait = -1, stable_cnt = 0;
    int overlap = 0, busy_bad = 0, unstable = 0, done_cyc = -1, idle_bad = 0;
    bit imp_active = 1'b0, seen_done = 1'b0, rst_hit = 1'b0;
    logic [VW:0] imp_hold = '0;
    walk_id++;
    build_model();
    @(negedge clock);
    base_addr = AW'(s_base); clause_cnt = (AW+1)'(s_cnt); start = 1'b1;
    while (!seen_done && !rst_hit && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      start = 1'($urandom); base_addr = AW'($urandom); clause_cnt = (AW+1)'($urandom_range(1, 20));
      ce_valid = 1'b0; ce_status = 2'($urandom); abort = 1'b0; imp_ready = 1'b0;
      if (32'(clause_rd_en) + 32'(ep_en) + 32'(imp_valid) > 1) overlap++;
      if (!busy) busy_bad++;
      if (clause_rd_en) begin
        if (rd_idx < e_reads.size()) begin
          chk("rd_addr", 64'(clause_rd_addr), 64'(e_reads[rd_idx]));
          chk("rd_cycle", 64'(cyc), 64'(e_rd_cyc[rd_idx]));
        end else chk("extra_read", 64'(rd_idx), 64'(e_reads.size()));
        rd_idx++;
        if (s_noise) begin ce_valid = 1'b1; ce_status = 2'b11; end
      end
      if (ep_en) begin
        if (ep_idx < e_reads.size())
          chk("ep_clause_info", 64'(ep_clause_info), 64'(mem[e_reads[ep_idx]]));
        else chk("extra_ep_en", 64'(ep_idx), 64'(e_reads.size()));
        cur = (ep_idx < 16) ? ep_idx : 15;
        ep_idx++;
        ce_wait = s_ce_dly[cur];
      end
      if (ce_wait == 0) begin
        ce_valid = 1'b1; ce_status = s_st[cur];
        ce_unit_var = s_var[cur]; ce_unit_val = s_val[cur];
        if (cur == s_abort_idx) abort = 1'b1;
        ce_wait = -1;
      end else if (ce_wait > 0) ce_wait--;
      if (imp_valid) begin
        if (s_rst_imply) begin
          #2 reset = 1'b0;
          #1 chk("outputs_in_reset", 64'({clause_rd_en, ep_en, imp_valid, busy, done, conflict,
                 |clause_rd_addr, |ep_clause_info, |imp_var, imp_val, |conflict_addr, |imp_count}), 64'(0));
          rst_hit = 1'b1;
        end else begin
          if (!imp_active) begin
            imp_active = 1'b1; stable_cnt = 0; imp_hold = {imp_var, imp_val};
            rdy_wait = s_rdy_dly[cur];
            if (imp_idx < e_imps.size()) chk("imp_var_val", 64'({imp_var, imp_val}), 64'(e_imps[imp_idx]));
            else chk("extra_imp", 64'(imp_idx), 64'(e_imps.size()));
          end else if ({imp_var, imp_val} !== imp_hold) unstable++;
          stable_cnt++;
          if (rdy_wait == 0) begin
            imp_ready = 1'b1; imp_active = 1'b0; imp_idx++; rdy_wait = -1;
            chk("imp_valid_cycles", 64'(stable_cnt), 64'(s_rdy_dly[cur] + 1));
          end else rdy_wait--;
        end
      end
      if (done) begin
        seen_done = 1'b1; done_cyc = cyc;
        start = 1'b1;
      end
    end
    if (rst_hit) begin
      @(negedge clock);
      start = 1'b0; ce_valid = 1'b0; abort = 1'b0; imp_ready = 1'b0;
      reset = 1'b1;
      repeat (4) begin
        @(negedge clock);
        if (done || busy || imp_valid || clause_rd_en) idle_bad++;
      end
      chk("idle_after_reset", 64'(idle_bad), 64'(0));
    end else begin
      chk("done_seen", 64'(seen_done), 64'(1));
      chk("done_cycle", 64'(done_cyc), 64'(e_done_cyc));
      chk("conflict", 64'(conflict), 64'(e_conf));
      chk("conflict_addr", 64'(conflict_addr), 64'(e_conf ? e_conf_addr : 0));
      chk("imp_count", 64'(imp_count), 64'(e_imp_cnt));
      chk("read_total", 64'(rd_idx), 64'(e_reads.size()));
      chk("imp_total", 64'(imp_idx), 64'(e_imps.size()));
      chk("strobe_overlap", 64'(overlap), 64'(0));
      chk("busy_in_walk", 64'(busy_bad), 64'(0));
      chk("imp_unstable", 64'(unstable), 64'(0));
      @(negedge clock);
      start = 1'b0; ce_valid = 1'b0; abort = 1'b0;
      chk("done_pulse_width", 64'(done), 64'(0));
      chk("idle_after_done", 64'(busy), 64'(0));
      chk("imp_count_hold", 64'(imp_count), 64'(e_imp_cnt));
      chk("conflict_hold", 64'(conflict), 64'(e_conf));
    end
  endtask

  initial begin
    logic [63:0] r;
    for (int i = 0; i < 1024; i++) begin
      r = {$urandom, $urandom};
      mem[i] = r[DW-1:0];
    end
    repeat (3) @(negedge clock);
    chk("reset_outputs", 64'({clause_rd_en, ep_en, imp_valid, busy, done, conflict,
        |clause_rd_addr, |ep_clause_info, |imp_var, imp_val, |conflict_addr, |imp_count}), 64'(0));
    reset = 1'b1;
    repeat (2) @(negedge clock);

    clear_scen(); s_base = 4; s_cnt = 3;
    run_walk();

    clear_scen(); s_base = 1; s_cnt = 2;
    s_st[0] = 2'b10; s_var[0] = 9'd7; s_val[0] = 1'b1; s_rdy_dly[0] = 4;
    run_walk();

    clear_scen(); s_base = 1022; s_cnt = 4; s_st[0] = 2'b00; s_st[1] = 2'b11;
    run_walk();

    clear_scen(); s_base = 100; s_cnt = 0;
    run_walk();

    clear_scen(); s_base = 37; s_cnt = 3; s_st[1] = 2'b10; s_abort_idx = 1;
    run_walk();

    clear_scen(); s_base = 1; s_cnt = 2; s_st[0] = 2'b10; s_rdy_dly[0] = 6; s_rst_imply = 1'b1;
    run_walk();
    clear_scen(); s_base = 500; s_cnt = 1; s_st[0] = 2'b10; s_rdy_dly[0] = 1;
    run_walk();

    for (int w = 0; w < 30; w++) begin
      clear_scen();
      s_base  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1016, 1023)) : int'($urandom_range(0, 1023));
      s_cnt   = $urandom_range(1, 12);
      s_noise = 1'($urandom);
      for (int i = 0; i < 16; i++) begin
        s_st[i]      = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        s_ce_dly[i]  = $urandom_range(0, 3);
        s_rdy_dly[i] = $urandom_range(0, 3);
      end
      if ($urandom_range(0, 4) == 0) s_abort_idx = $urandom_range(0, s_cnt - 1);
      run_walk();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
